// File: rtl/lcd_pkg.sv
// Shared constants and state types for the HD44780 4-bit character LCD driver.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  // Enable strobe shape, in clk cycles
  localparam logic [31:0] STROBE_SETUP = 32'd2;
  localparam logic [31:0] STROBE_EN    = 32'd12;
  localparam logic [31:0] STROBE_HOLD  = 32'd1;

  // Nibble index of the last step of each sequence (12 init nibbles, 34 refresh bytes)
  localparam logic [6:0] INIT_LAST_STEP    = 7'd11;
  localparam logic [6:0] REFRESH_LAST_STEP = 7'd67;

  typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, REFRESH} lcd_state_e;
  typedef enum logic [2:0] {W_IDLE, W_SETUP, W_EN, W_HOLD, W_POST} wr_state_e;

endpackage

// File: rtl/lcd_nibble_writer.sv
// Writes one nibble to the panel with setup/enable/hold framing, then waits a
// caller-supplied number of cycles before pulsing done_o.
module lcd_nibble_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        rs_i,
  input  logic [3:0]  nib_i,
  input  logic [31:0] post_i,
  output logic        elcd_o,
  output logic        rs_o,
  output logic [3:0]  nib_o,
  output logic        done_o
);
  import lcd_pkg::*;

  wr_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] post_q, post_d;
  logic        elcd_q, elcd_d;
  logic        rs_q, rs_d;
  logic [3:0]  nib_q, nib_d;
  logic        done_q, done_d;

  // elcd is a register so an asynchronous reset drops the strobe immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= W_IDLE;
      cnt_q   <= '0;
      post_q  <= '0;
      elcd_q  <= 1'b0;
      rs_q    <= 1'b0;
      nib_q   <= 4'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      elcd_q  <= elcd_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    post_d  = post_q;
    elcd_d  = elcd_q;
    rs_d    = rs_q;
    nib_d   = nib_q;
    done_d  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (start_i) begin
          rs_d    = rs_i;
          nib_d   = nib_i;
          post_d  = post_i;
          cnt_d   = STROBE_SETUP - 32'd1;
          state_d = W_SETUP;
        end
      end
      W_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_EN - 32'd1;
          elcd_d  = 1'b1;
          state_d = W_EN;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      W_EN: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_HOLD - 32'd1;
          elcd_d  = 1'b0;
          state_d = W_HOLD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      W_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (post_q == '0) begin
          done_d  = 1'b1;
          state_d = W_IDLE;
        end else begin
          cnt_d   = post_q - 32'd1;
          state_d = W_POST;
        end
      end
      W_POST: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = W_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign elcd_o = elcd_q;
  assign rs_o   = rs_q;
  assign nib_o  = nib_q;
  assign done_o = done_q;

endmodule

// File: rtl/lcd_text_display.sv
// 16x2 HD44780 driver: power-up init, then copies a 32-byte frame buffer to the panel.
// Define LCD_AUTO_REFRESH_EN to refresh continuously from IDLE every CMD_US.
module lcd_text_display #(
  parameter int CLK_MHZ  = 50,
  parameter int PWRON_US = 15000,
  parameter int CMD_US   = 40,
  parameter int CLR_US   = 1640
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cls,
  input  logic [255:0] strdata,
  output logic         rslcd,
  output logic         rwlcd,
  output logic         elcd,
  output logic [3:0]   lcdd
);
  import lcd_pkg::*;

  localparam logic [31:0] C_PWR  = 32'(PWRON_US * CLK_MHZ);
  localparam logic [31:0] C_4100 = 32'(4100 * CLK_MHZ);
  localparam logic [31:0] C_100  = 32'(100 * CLK_MHZ);
  localparam logic [31:0] C_CMD  = 32'(CMD_US * CLK_MHZ);
  localparam logic [31:0] C_CLR  = 32'(CLR_US * CLK_MHZ);
  localparam logic [31:0] C_GAP  = 32'(CLK_MHZ);

  lcd_state_e   state_q, state_d;
  logic [6:0]   step_q, step_d;
  logic         busy_q, busy_d;
  logic [31:0]  delay_q, delay_d;
  logic         pending_q, pending_d;
  logic [255:0] shadow_q, shadow_d;

  logic         wr_start, wr_done;
  logic         step_rs;
  logic [3:0]   step_nib;
  logic [31:0]  step_post;
  logic [7:0]   byte_v;
  logic [5:0]   byte_idx;
  logic [4:0]   ch_idx;
  logic [6:0]   last_step;

  // Each step is one nibble; even steps carry the high half of a byte
  always_comb begin
    byte_idx  = step_q[6:1];
    ch_idx    = (byte_idx < 6'd17) ? 5'(byte_idx - 6'd1) : 5'(byte_idx - 6'd2);
    byte_v    = 8'h00;
    step_rs   = 1'b0;
    last_step = (state_q == INIT) ? INIT_LAST_STEP : REFRESH_LAST_STEP;
    if (state_q == INIT) begin
      case (byte_idx)
        6'd2:    byte_v = LCD_FUNC_SET;
        6'd3:    byte_v = LCD_ENTRY;
        6'd4:    byte_v = LCD_DISP_ON;
        default: byte_v = LCD_CLEAR;
      endcase
    end else if (byte_idx == 6'd0) begin
      byte_v = LCD_LINE1;
    end else if (byte_idx == 6'd17) begin
      byte_v = LCD_LINE2;
    end else begin
      step_rs = 1'b1;
      byte_v  = shadow_q[{~ch_idx, 3'b111} -: 8];
    end
    step_nib  = step_q[0] ? byte_v[3:0] : byte_v[7:4];
    step_post = !step_q[0] ? C_GAP :
                ((byte_v == LCD_CLEAR && !step_rs) ? C_CLR : C_CMD);
    // The first four init writes are bare nibbles with their own waits
    if (state_q == INIT && step_q < 7'd4) begin
      step_nib = (step_q == 7'd3) ? 4'h2 : 4'h3;
      case (step_q)
        7'd0:    step_post = C_4100;
        7'd1:    step_post = C_100;
        default: step_post = C_CMD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PWR_WAIT;
      step_q    <= '0;
      busy_q    <= 1'b0;
      delay_q   <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      delay_q   <= delay_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    busy_d    = busy_q;
    delay_d   = delay_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    wr_start  = 1'b0;
    if (cls && state_q != IDLE) pending_d = 1'b1;
    case (state_q)
      PWR_WAIT: begin
        if (delay_q >= C_PWR - 32'd1) begin
          state_d = INIT;
          step_d  = '0;
          delay_d = '0;
        end else begin
          delay_d = delay_q + 32'd1;
        end
      end
      INIT, REFRESH: begin
        if (!busy_q) begin
          wr_start = 1'b1;
          busy_d   = 1'b1;
        end else if (wr_done) begin
          busy_d = 1'b0;
          if (step_q == last_step) begin
            step_d  = '0;
            delay_d = '0;
            if (state_q == INIT) begin
              state_d   = REFRESH;
              shadow_d  = strdata;
              pending_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            step_d = step_q + 7'd1;
          end
        end
      end
      IDLE: begin
        if (cls || pending_q) begin
          state_d   = REFRESH;
          step_d    = '0;
          shadow_d  = strdata;
          pending_d = 1'b0;
          delay_d   = '0;
        end
`ifdef LCD_AUTO_REFRESH_EN
        else if (delay_q >= C_CMD - 32'd1) begin
          state_d  = REFRESH;
          step_d   = '0;
          shadow_d = strdata;
          delay_d  = '0;
        end else begin
          delay_d = delay_q + 32'd1;
        end
`endif
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  lcd_nibble_writer u_writer (
    .clk     (clk),
    .rst     (rst),
    .start_i (wr_start),
    .rs_i    (step_rs),
    .nib_i   (step_nib),
    .post_i  (step_post),
    .elcd_o  (elcd),
    .rs_o    (rslcd),
    .nib_o   (lcdd),
    .done_o  (wr_done)
  );

  assign rwlcd = 1'b0;

endmodule

// File: tb/tb_lcd_text_display.sv
// Scoreboard bench for lcd_text_display: stimulus queues expected nibbles, a
// monitor captures every enable strobe and compares it against the queue.
module tb_lcd_text_display;

  logic         clk = 1'b0;
  logic         rst;
  logic         cls;
  logic [255:0] strdata;
  logic         rslcd, rwlcd, elcd;
  logic [3:0]   lcdd;

  typedef struct packed {
    logic       rs;
    logic [3:0] nib;
    logic       gap;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lcd_text_display #(
    .CLK_MHZ  (1),
    .PWRON_US (20),
    .CMD_US   (40),
    .CLR_US   (50)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cls     (cls),
    .strdata (strdata),
    .rslcd   (rslcd),
    .rwlcd   (rwlcd),
    .elcd    (elcd),
    .lcdd    (lcdd)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushNib(input logic rs, input logic [3:0] nib, input logic gap);
    exp_t e;
    e.rs  = rs;
    e.nib = nib;
    e.gap = gap;
    expQ.push_back(e);
  endtask

  task automatic pushByte(input logic rs, input logic [7:0] b, input logic gap);
    pushNib(rs, b[7:4], 1'b0);
    pushNib(rs, b[3:0], gap);
  endtask

  task automatic pushInit();
    pushNib(1'b0, 4'h3, 1'b0);
    pushNib(1'b0, 4'h3, 1'b0);
    pushNib(1'b0, 4'h3, 1'b0);
    pushNib(1'b0, 4'h2, 1'b0);
    pushByte(1'b0, 8'h28, 1'b0);
    pushByte(1'b0, 8'h06, 1'b0);
    pushByte(1'b0, 8'h0C, 1'b0);
    pushByte(1'b0, 8'h01, 1'b1);
  endtask

  task automatic pushRefresh(input logic [255:0] s);
    pushByte(1'b0, 8'h80, 1'b0);
    for (int i = 0; i < 16; i++) pushByte(1'b1, s[255 - 8*i -: 8], 1'b0);
    pushByte(1'b0, 8'hC0, 1'b0);
    for (int i = 16; i < 32; i++) pushByte(1'b1, s[255 - 8*i -: 8], 1'b0);
  endtask

  // One-cycle cls pulse; optionally reports cycles until elcd first rises
  task automatic applyStimulus(input bit measure, output int lat);
    @(negedge clk);
    cls = 1'b1;
    @(posedge clk);
    #1 cls = 1'b0;
    lat = 0;
    if (measure) begin
      for (int n = 1; n <= 8; n++) begin
        @(posedge clk);
        #1;
        if (elcd === 1'b1) begin
          lat = n;
          break;
        end
      end
    end
  endtask

  task automatic quietCycles(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (elcd !== 1'b0) highs++;
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  // Monitor: frames each strobe, checks width, payload and the post-clear gap
  initial begin
    bit         inHigh  = 0;
    bit         gapArmed = 0;
    int         hiCnt   = 0;
    int         lowCnt  = 0;
    logic       capRs   = 1'b0;
    logic [3:0] capNib  = 4'h0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        inHigh   = 0;
        gapArmed = 0;
        hiCnt    = 0;
        lowCnt   = 0;
        continue;
      end
      if (elcd === 1'b1) begin
        if (!inHigh) begin
          inHigh = 1;
          hiCnt  = 0;
          capRs  = rslcd;
          capNib = lcdd;
          if (gapArmed) begin
            checkOutput("clearGapAtLeast50", 32'(lowCnt >= 50), 1);
            gapArmed = 0;
          end
        end
        hiCnt++;
      end else if (inHigh) begin
        inHigh = 0;
        lowCnt = 0;
        checkOutput("strobeWidth", hiCnt, 12);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedStrobe: got rs=%0d nib=0x%0h, expected no strobe", capRs, capNib);
        end else begin
          e = expQ.pop_front();
          checkOutput("strobeRsNib", {27'd0, capRs, capNib}, {27'd0, e.rs, e.nib});
          if (e.gap) gapArmed = 1;
        end
      end else begin
        lowCnt++;
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] s;
    int lat;
    int highs;
    int n;
    s       = "01234567 00 0123f01d01e01m01w01 ";
    rst     = 1'b1;
    cls     = 1'b0;
    strdata = s;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetElcd", elcd, 0);
    checkOutput("resetRs", rslcd, 0);
    checkOutput("resetRw", rwlcd, 0);
    checkOutput("resetLcdd", lcdd, 0);

    $display("[TB] power-on, init and first refresh");
    pushInit();
    pushRefresh(s);
    @(negedge clk);
    rst = 1'b0;
    quietCycles(20, highs);
    checkOutput("powerOnQuiet", highs, 0);
    waitDrain("initRefreshDrained", 12000);
    quietCycles(200, highs);
    checkOutput("idleQuietAfterInit", highs, 0);

    $display("[TB] cls after changing line 1 column 0");
    s[255:248] = 8'h41;
    strdata    = s;
    pushRefresh(s);
    applyStimulus(1'b1, lat);
    checkOutput("clsToElcdLatency", lat, 3);
    waitDrain("clsRefreshDrained", 5000);
    quietCycles(200, highs);
    checkOutput("idleQuietAfterCls", highs, 0);

    $display("[TB] two cls pulses during a refresh");
    pushRefresh(s);
    pushRefresh(s);
    applyStimulus(1'b0, lat);
    repeat (100) @(posedge clk);
    applyStimulus(1'b0, lat);
    repeat (300) @(posedge clk);
    applyStimulus(1'b0, lat);
    waitDrain("pendingRefreshDrained", 9000);
    quietCycles(300, highs);
    checkOutput("noThirdRefresh", highs, 0);

    $display("[TB] reset in the middle of a refresh");
    pushRefresh(s);
    applyStimulus(1'b0, lat);
    repeat (600) @(posedge clk);
    #1;
    n = 0;
    while (elcd !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("midRefreshStrobeSeen", elcd, 1);
    #2 rst = 1'b1;
    #1 checkOutput("elcdAsyncReset", elcd, 0);
    repeat (3) @(posedge clk);
    expQ.delete();
    pushInit();
    pushRefresh(s);
    @(negedge clk);
    rst = 1'b0;
    quietCycles(20, highs);
    checkOutput("powerOnQuietAfterRst", highs, 0);
    waitDrain("reinitDrained", 12000);
    quietCycles(200, highs);
    checkOutput("idleQuietAfterReinit", highs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
